// File: rtl/fwd_pkg.sv
// fwd_pkg: shared constants, buffer state encoding and small helpers for the
// operand-forwarding selector (fwd_mux_sel / fwd_mux_pipe).
//
// Contents:
//   FWD_DEFAULT_WIDTH   default operand width
//   FWD_SRC_RF/MEM/WB   conventional source indices in the flattened bus
//   fwd_state_e         output buffer state, encoded as {main_valid, skid_valid}
//   fwd_main_valid()    main entry holds a beat
//   fwd_skid_valid()    skid entry holds a beat
package fwd_pkg;

    localparam int FWD_DEFAULT_WIDTH = 32;

    // Source 0 is the register-file value and doubles as the fallback for
    // select codes outside the populated range.
    localparam int FWD_SRC_RF  = 0;
    localparam int FWD_SRC_MEM = 1;
    localparam int FWD_SRC_WB  = 2;

    // Bit 1 = main entry valid, bit 0 = skid entry valid. Code 2'b01 has no
    // name because the skid can never be occupied while main is empty.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } fwd_state_e;

    function automatic logic fwd_main_valid(input fwd_state_e state);
        return state[1];
    endfunction

    function automatic logic fwd_skid_valid(input fwd_state_e state);
        return state[0];
    endfunction

endpackage

// File: rtl/fwd_mux_pipe_chk.sv
// fwd_mux_pipe_chk: simulation checker bound into fwd_mux_pipe.
// Watches the buffer state encoding and the ready/skid relationship, and,
// when FWD_MUX_SEL_CHK_EN is defined, flags accepted out-of-range selects.
//
// Ports:
//   clk_i, rst_i  clock and asynchronous active-high reset
//   state         buffer state {main_valid, skid_valid}
//   in_ready      registered ready presented upstream
//   accept        (FWD_MUX_SEL_CHK_EN only) beat accepted this cycle
//   sel_oob       (FWD_MUX_SEL_CHK_EN only) select of that beat is out of range
module fwd_mux_pipe_chk (
    input logic       clk_i,
    input logic       rst_i,
    input logic [1:0] state,
    input logic       in_ready
`ifdef FWD_MUX_SEL_CHK_EN
    ,
    input logic       accept,
    input logic       sel_oob
`endif
);

    // Skid can only hold a beat behind an occupied main entry.
    a_no_skid_only: assert property (@(posedge clk_i) disable iff (rst_i)
        state != 2'b01)
        else $error("fwd_mux_pipe: skid valid while main empty");

    // Upstream ready is exactly the inverse of skid occupancy.
    a_ready_tracks_skid: assert property (@(posedge clk_i) disable iff (rst_i)
        in_ready == !state[0])
        else $error("fwd_mux_pipe: in_ready disagrees with skid state");

`ifdef FWD_MUX_SEL_CHK_EN
    // Report each accepted beat carrying an out-of-range select.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            a_sel_in_range: assert (!(accept && sel_oob))
                else $warning("fwd_mux_pipe: accepted out-of-range select");
        end
    end
`endif

endmodule

// File: rtl/fwd_mux_sel.sv
// fwd_mux_sel: purely combinational NUM_SRC-way operand selector.
// Any select code at or above NUM_SRC falls back to the register-file source,
// so every code produces a defined result.
//
// Ports:
//   src_data  in   NUM_SRC*WIDTH  flattened sources, source k at [k*WIDTH +: WIDTH]
//   select    in   SEL_W          binary source select
//   sel_data  out  WIDTH          selected source
module fwd_mux_sel
    import fwd_pkg::*;
#(
    parameter int  WIDTH   = FWD_DEFAULT_WIDTH,
    parameter int  NUM_SRC = 3,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         select,
    output logic [WIDTH-1:0]         sel_data
);

    logic [31:0]      sel_ext_s;
    logic [SEL_W-1:0] idx_s;

    // Clamp the select to a populated source, then pick that slice.
    always_comb begin
        sel_ext_s = 32'(select);
        idx_s     = (sel_ext_s < 32'(NUM_SRC)) ? select : SEL_W'(FWD_SRC_RF);
        sel_data  = src_data[idx_s * WIDTH +: WIDTH];
    end

endmodule

// File: rtl/fwd_mux_pipe.sv
// fwd_mux_pipe: operand-forwarding selector with registered output behind a
// valid/ready handshake and a one-entry skid buffer.
//
// Optional feature macro: FWD_MUX_SEL_CHK_EN adds sticky sel_err_o, set after
// any accepted beat whose select is >= NUM_SRC, cleared only by rst_i.
//
// Ports:
//   clk_i        in   1              clock, rising edge
//   rst_i        in   1              asynchronous active-high reset
//   in_valid_i   in   1              upstream beat valid
//   in_ready_o   out  1              block can accept a beat (registered)
//   data_i       in   NUM_SRC*WIDTH  flattened sources
//   select_i     in   SEL_W          forwarding select, sampled with the beat
//   flush_i      in   1              synchronous flush of all held beats
//   out_valid_o  out  1              data_o holds a valid operand
//   out_ready_i  in   1              downstream accepts data_o
//   data_o       out  WIDTH          selected, registered operand
//   sel_err_o    out  1              (FWD_MUX_SEL_CHK_EN only) sticky select error
module fwd_mux_pipe
    import fwd_pkg::*;
#(
    parameter int  WIDTH   = FWD_DEFAULT_WIDTH,
    parameter int  NUM_SRC = 3,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_SRC*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]         select_i,
    input  logic                     flush_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         data_o
`ifdef FWD_MUX_SEL_CHK_EN
    ,
    output logic                     sel_err_o
`endif
);

    fwd_state_e       state_r;
    fwd_state_e       state_next_s;
    logic             in_ready_r;
    logic [WIDTH-1:0] main_data_r;
    logic [WIDTH-1:0] skid_data_r;
    logic [WIDTH-1:0] sel_data_s;
    logic             accept_s;
    logic             emit_s;
    logic             load_main_s;
    logic             load_skid_s;
    logic             skid_to_main_s;

    fwd_mux_sel #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC)
    ) u_sel (
        .src_data (data_i),
        .select   (select_i),
        .sel_data (sel_data_s)
    );

    // Next-state and datapath load enables; flush wins over accept and emit.
    always_comb begin
        accept_s       = in_valid_i & in_ready_r;
        emit_s         = fwd_main_valid(state_r) & out_ready_i;
        state_next_s   = state_r;
        load_main_s    = 1'b0;
        load_skid_s    = 1'b0;
        skid_to_main_s = 1'b0;
        if (flush_i) begin
            state_next_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_next_s = ONE;
                        load_main_s  = 1'b1;
                    end else begin
                        state_next_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && emit_s) begin
                        state_next_s = ONE;
                        load_main_s  = 1'b1;
                    end else if (emit_s) begin
                        state_next_s = EMPTY;
                    end else if (accept_s) begin
                        state_next_s = TWO;
                        load_skid_s  = 1'b1;
                    end else begin
                        state_next_s = ONE;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the emit path matters.
                    if (emit_s) begin
                        state_next_s   = ONE;
                        skid_to_main_s = 1'b1;
                    end else begin
                        state_next_s = TWO;
                    end
                end
                default: begin
                    state_next_s = EMPTY;
                end
            endcase
        end
    end

    // Buffer state and registered upstream ready (high whenever skid is free).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            in_ready_r <= !fwd_skid_valid(state_next_s);
        end
    end

    // Operand storage; main is left untouched on flush so data_o is not cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_data_r <= {WIDTH{1'b0}};
            skid_data_r <= {WIDTH{1'b0}};
        end else begin
            if (load_main_s) begin
                main_data_r <= sel_data_s;
            end else if (skid_to_main_s) begin
                main_data_r <= skid_data_r;
            end
            if (load_skid_s) begin
                skid_data_r <= sel_data_s;
            end
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = fwd_main_valid(state_r);
    assign data_o      = main_data_r;

`ifdef FWD_MUX_SEL_CHK_EN
    logic sel_oob_s;
    logic sel_err_r;

    assign sel_oob_s = (32'(select_i) >= 32'(NUM_SRC));

    // Sticky select-error flag; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_err_r <= 1'b0;
        end else if (accept_s && sel_oob_s) begin
            sel_err_r <= 1'b1;
        end
    end

    assign sel_err_o = sel_err_r;
`endif

    fwd_mux_pipe_chk u_chk (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .state    (state_r),
        .in_ready (in_ready_r)
`ifdef FWD_MUX_SEL_CHK_EN
        ,
        .accept   (accept_s),
        .sel_oob  (sel_oob_s)
`endif
    );

endmodule

// File: doc/fwd_mux_pipe.md
Name: fwd_mux_pipe

Overview:
- Parametrised N-source operand-forwarding selector for the pipelined CPU datapath.
- Selects one of NUM_SRC WIDTH-bit candidates (register file, EX/MEM, MEM/WB, …) by a binary select, then registers the result.
- Output goes behind a valid/ready handshake with a one-entry skid buffer, so the EX stage can stall without losing a forwarded operand.
- Gives fully defined behaviour for every select code and supports a synchronous pipeline flush.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- NUM_SRC, 3, number of forwarding sources; legal range 2..16.
- SEL_W, $clog2(NUM_SRC), select width; localparam, not overridable.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  block can accept a beat this cycle.
- data_i  in  NUM_SRC*WIDTH  flattened sources; source k is bits [k*WIDTH +: WIDTH].
- select_i  in  SEL_W  forwarding select; sampled with the beat.
- flush_i  in  1  synchronous flush of all held beats.
- out_valid_o  out  1  data_o holds a valid operand.
- out_ready_i  in  1  downstream accepts data_o.
- data_o  out  WIDTH  selected, registered operand.

Behaviour:
- Reset (rst_i high, asynchronous): main and skid entries invalid; data_o=0; out_valid_o=0; in_ready_o=1 (held 1 during reset).
- Selection (combinational, before the register):
  - select_i < NUM_SRC: choose source select_i.
  - select_i >= NUM_SRC: choose source 0 (register-file value). No latch; every code is defined.
- Accept = in_valid_i & in_ready_o. Emit = out_valid_o & out_ready_i.
- in_ready_o = !skid_valid. It is registered-state derived and never depends combinationally on out_ready_i.
- State machine, encoded by (main_valid, skid_valid):
  - EMPTY (0,0): accept -> load main, go to ONE.
  - ONE (1,0):
    - accept & emit -> main reloads, stay in ONE.
    - emit only -> EMPTY.
    - accept only -> load skid, go to TWO.
  - TWO (1,1): in_ready_o=0. Emit -> skid moves to main, skid cleared, go to ONE.
  - (0,1) is unreachable; an assertion covers it.
- Latency: 1 cycle from accept to out_valid_o when the output is empty. Throughput 1 beat/cycle while out_ready_i=1.
- Ordering is strict FIFO; the skid beat is never emitted before the main beat.
- data_o holds its value while out_valid_o=1 and out_ready_i=0.
- data_o keeps its last value after emit; it is don't-care while out_valid_o=0.
- Flush: flush_i high at a clock edge clears main and skid to EMPTY.
  - A beat accepted in the same cycle is discarded.
  - Flush overrides emit and accept.
  - data_o is not cleared.
- Reset mid-operation: held beats are lost immediately; no emit follows reset.

Optional Feature:
- Macro: FWD_MUX_SEL_CHK_EN.
- Defined:
  - Adds port sel_err_o (out, 1).
  - sel_err_o is sticky; it is set on the edge after an accepted beat with select_i >= NUM_SRC.
  - Cleared only by rst_i.
  - Adds an immediate assertion on that condition for simulation.
- Undefined: port absent; out-of-range selects silently map to source 0.

Decomposition:
- Package fwd_pkg:
  - Source index constants FWD_SRC_RF=0, FWD_SRC_MEM=1, FWD_SRC_WB=2.
  - Buffer state enum {EMPTY, ONE, TWO}.
  - Default width constant 32.
- Sub-module fwd_mux_sel: purely combinational NUM_SRC-way select with the out-of-range default.
- fwd_mux_pipe instantiates fwd_mux_sel and contains the skid/handshake logic.

Test Plan:
- Reset, then one beat: rst_i pulse, then one beat with sources {0x11,0x22,0x33}, select=2, out_ready_i=1 -> out_valid_o=1 next cycle, data_o=0x33; in_ready_o=1 throughout.
- Streaming: 4 beats back-to-back with select 0,1,2,1 and out_ready_i=1 -> data_o sequence 0x11,0x22,0x33,0x22 on consecutive cycles with no bubbles.
- Back-pressure: out_ready_i=0, push beats A (sel 1) and B (sel 2) -> in_ready_o=0 after B. Raise out_ready_i -> A (0x22) then B (0x33), then in_ready_o returns to 1.
- Out-of-range select (NUM_SRC=3): select=3 -> data_o=0x11. With FWD_MUX_SEL_CHK_EN, sel_err_o=1 and stays 1 until reset.
- Flush in TWO state: flush_i together with in_valid_i -> out_valid_o=0 next cycle, in_ready_o=1; the new beat is never emitted.
- Asynchronous reset mid-stall: assert rst_i between clock edges while in TWO -> out_valid_o=0 immediately, no stale beat after release.
